// File: rtl/int2fp16_vec_seq_pkg.sv
// Shared definitions for the SMC INT-to-FP lane sequencer.
// Contents: FSM state enum, fp16 constants, lane width.
package smc_i2f_pkg;

  localparam int unsigned LANE_W = 16;

  localparam logic [LANE_W-1:0] FP16_POS_INF = 16'h7C00;
  localparam logic [LANE_W-1:0] FP16_ZERO    = 16'h0000;

  typedef enum logic [1:0] {
    I2F_IDLE,
    I2F_CONV,
    I2F_DRAIN,
    I2F_DONE
  } i2f_state_e;

endpackage

// File: rtl/int2fp16_vec_seq_if.sv
// Streaming bus of the int16-vector to fp16-vector sequencer.
// master: vector source and result sink (drives in_*, out_ready).
// slave:  the sequencer (drives in_ready, out_valid, out_data, busy).
interface int2fp16_vec_seq_if #(
  parameter int unsigned LANES = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*16-1:0]   in_data;
  logic                  in_signed;
  logic [LANES-1:0]      in_mask;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*16-1:0]   out_data;
  logic                  busy;

  modport master (
    output in_valid, in_data, in_signed, in_mask, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_mask, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/int2fp16_vec_seq_conv.sv
// Combinational scalar int16 -> fp16 converter (bias 15, round-to-nearest-even).
// Ports:
//   a         int16 input
//   is_signed treat a as two's complement when 1, unsigned when 0
//   y         fp16 result; zero maps to +0, unsigned >= 65520 rounds to +Inf
module int2fp16
  import smc_i2f_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic              is_signed,
  output logic [LANE_W-1:0] y
);

  logic              sign;
  logic [LANE_W-1:0] mag;
  logic [LANE_W-1:0] norm;
  logic [3:0]        lead;
  logic [4:0]        expo;
  logic [9:0]        mant;
  logic              rnd;

  always_comb begin
    sign = is_signed & a[15];
    // -32768 negates to 16'h8000, still representable as an unsigned magnitude
    mag  = sign ? (~a + 16'd1) : a;
    lead = '0;
    for (int i = 0; i < 16; i++) begin
      if (mag[i]) lead = 4'(i);
    end
    norm = mag << (4'd15 - lead);
    mant = norm[14:5];
    rnd  = norm[4] & ((|norm[3:0]) | norm[5]);
    expo = 5'd15 + {1'b0, lead};
    // Mantissa carry ripples into the exponent; 30 + carry gives the Inf code
    if (mag == '0) y = FP16_ZERO;
    else           y = {sign, expo, mant} + {15'd0, rnd};
  end

endmodule

// File: rtl/int2fp16_vec_seq.sv
// Lane sequencer: accepts a vector of LANES int16 lanes, converts one lane per
// cycle through a single shared int2fp16, and presents the packed fp16 vector.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  int2fp16_vec_seq_if.slave (in_valid/in_ready/in_data/in_signed/in_mask,
//        out_valid/out_ready/out_data, busy)
// Build option: define I2F_PIPE_EN to register the converter output; each lane
// is then written one cycle after issue and a DRAIN cycle writes the last lane.
module int2fp16_vec_seq
  import smc_i2f_pkg::*;
#(
  parameter int unsigned LANES = 8
) (
  input logic                clk,
  input logic                rst,
  int2fp16_vec_seq_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(LANES);

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  i2f_state_e       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  vec_t             data_q, data_d;
  vec_t             out_q, out_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic             signed_q, signed_d;
  logic [LANE_W-1:0] conv_y;
  logic [LANE_W-1:0] lane_res;
  logic             in_ready;
  logic             accept;
  logic             last_lane;

`ifdef I2F_PIPE_EN
  logic              pipe_vld_q, pipe_vld_d;
  logic [IdxW-1:0]   pipe_idx_q, pipe_idx_d;
  logic [LANE_W-1:0] pipe_res_q, pipe_res_d;
`endif

  int2fp16 u_conv (
    .a        (data_q[idx_q]),
    .is_signed(signed_q),
    .y        (conv_y)
  );

  assign lane_res  = mask_q[idx_q] ? conv_y : FP16_ZERO;
  assign last_lane = (idx_q == IdxW'(LANES - 1));
  // Gated by rst so the source never sees a handshake while reset is held
  assign in_ready  = !rst && ((state_q == I2F_IDLE) ||
                              ((state_q == I2F_DONE) && bus.out_ready));
  assign accept    = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == I2F_DONE);
  assign bus.out_data  = out_q;
  assign bus.busy      = (state_q == I2F_CONV) || (state_q == I2F_DRAIN);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    mask_d   = mask_q;
    signed_d = signed_q;
    out_d    = out_q;
`ifdef I2F_PIPE_EN
    pipe_vld_d = 1'b0;
    pipe_idx_d = idx_q;
    pipe_res_d = lane_res;
    if (pipe_vld_q) out_d[pipe_idx_q] = pipe_res_q;
`endif

    if (accept) begin
      data_d   = bus.in_data;
      mask_d   = bus.in_mask;
      signed_d = bus.in_signed;
      idx_d    = '0;
    end

    case (state_q)
      I2F_IDLE: begin
        if (accept) state_d = I2F_CONV;
      end
      I2F_CONV: begin
`ifdef I2F_PIPE_EN
        pipe_vld_d = 1'b1;
`else
        out_d[idx_q] = lane_res;
`endif
        if (last_lane) begin
          idx_d = '0;
`ifdef I2F_PIPE_EN
          state_d = I2F_DRAIN;
`else
          state_d = I2F_DONE;
`endif
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      I2F_DRAIN: begin
        // Last lane leaves the pipe register this cycle
        state_d = I2F_DONE;
      end
      I2F_DONE: begin
        if (bus.out_ready) state_d = accept ? I2F_CONV : I2F_IDLE;
      end
      default: state_d = I2F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= I2F_IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      signed_q <= 1'b0;
      out_q    <= '0;
`ifdef I2F_PIPE_EN
      pipe_vld_q <= 1'b0;
      pipe_idx_q <= '0;
      pipe_res_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      signed_q <= signed_d;
      out_q    <= out_d;
`ifdef I2F_PIPE_EN
      pipe_vld_q <= pipe_vld_d;
      pipe_idx_q <= pipe_idx_d;
      pipe_res_q <= pipe_res_d;
`endif
    end
  end

endmodule

// File: tb/tb_int2fp16_vec_seq.sv
// Scoreboard bench for int2fp16_vec_seq: the driver pushes expected vectors and
// accept-edge numbers; a monitor pops and compares on every output handshake.
module tb_int2fp16_vec_seq;

  localparam int unsigned LANES = 8;
  localparam int unsigned W     = LANES * 16;
`ifdef I2F_PIPE_EN
  localparam int EXP_LAT = LANES + 2;
`else
  localparam int EXP_LAT = LANES + 1;
`endif

  localparam logic [W-1:0] U_D = {16'hFFFF, 16'h8000, 16'h0000, 16'h0803,
                                  16'h0801, 16'h0400, 16'h0002, 16'h0001};
  localparam logic [W-1:0] U_E = {16'h7C00, 16'h7800, 16'h0000, 16'h6802,
                                  16'h6800, 16'h6400, 16'h4000, 16'h3C00};
  localparam logic [W-1:0] UM_E = {16'h7C00, 16'h0000, 16'h0000, 16'h0000,
                                   16'h0000, 16'h6400, 16'h0000, 16'h3C00};
  localparam logic [W-1:0] S_D = {16'hFC00, 16'h0007, 16'h0000, 16'h0064,
                                  16'hFFFE, 16'h8000, 16'hFFFF, 16'h0001};
  localparam logic [W-1:0] S_E = {16'hE400, 16'h4700, 16'h0000, 16'h5640,
                                  16'hC000, 16'hF800, 16'hBC00, 16'h3C00};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  int2fp16_vec_seq_if #(.LANES(LANES)) bus ();

  int2fp16_vec_seq #(.LANES(LANES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Presents a vector and waits (bounded) for the handshake edge.
  task automatic send(input logic [W-1:0] d, input logic sg, input logic [LANES-1:0] m,
                      input logic [W-1:0] e, input bit track);
    int n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_signed = sg;
    bus.in_mask   = m;
    #1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", W'(0), W'(1));
    end else if (track) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: latency on each rising out_valid, data on each handshake,
  // stability across every stalled cycle.
  initial begin : monitor
    logic         prev_valid = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (prev_stall) begin
        chk("stall_valid", W'(bus.out_valid), W'(1));
        chk("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && !prev_valid) begin
        if (acc_q.size() == 0) chk("unexpected_valid", W'(1), W'(0));
        else chk("latency", W'(cyc - acc_q.pop_front() + 1), W'(EXP_LAT));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", bus.out_data, '0);
        else chk("out_data", bus.out_data, exp_q.pop_front());
      end
      prev_valid = bus.out_valid;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  initial begin : driver
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(bus.in_ready), W'(0));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_out_data", bus.out_data, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", W'(bus.in_ready), W'(1));

    // Unsigned, signed back-to-back, then masked
    send(U_D, 1'b0, 8'hFF, U_E, 1'b1);
    #1;
    chk("busy_in_conv", W'(bus.busy), W'(1));
    send(S_D, 1'b1, 8'hFF, S_E, 1'b1);
    send(U_D, 1'b0, 8'b1010_0101, UM_E, 1'b1);

    // Stall in DONE with a pending input, then same-edge accept
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(S_D, 1'b1, 8'hFF, S_E, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_done", W'(bus.out_valid), W'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = U_D;
      bus.in_signed = 1'b0;
      bus.in_mask   = 8'hFF;
      #1;
      chk("stall_in_ready", W'(bus.in_ready), W'(0));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("same_edge_in_ready", W'(bus.in_ready), W'(1));
    if (bus.in_ready) begin
      exp_q.push_back(U_E);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    // Reset while lane 4 is in flight; the vector is discarded
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    send(S_D, 1'b1, 8'hFF, S_E, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", W'(bus.out_valid), W'(0));
    chk("midrst_out_data", bus.out_data, '0);
    chk("midrst_busy", W'(bus.busy), W'(0));
    chk("midrst_in_ready", W'(bus.in_ready), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_midrst", W'(bus.in_ready), W'(1));
    send(U_D, 1'b0, 8'hFF, U_E, 1'b1);

    n = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", W'(exp_q.size() + acc_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int2fp16_vec_seq.md
# int2fp16_vec_seq

Lane sequencer that sits directly upstream of the scalar `int2fp16` converter in the SMC INT-to-FP path. It accepts one packed vector of int16 lanes per transaction and feeds the lanes one per cycle through a single shared converter. It collects the fp16 results into a packed output vector, giving a valid/ready streaming unit for one converter's worth of area.

## Interface
Parameters:
- `LANES`, 8: number of 16-bit lanes per vector (≥2, power of 2).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input vector valid.
- `in_ready` out 1: block can accept a vector.
- `in_data` in LANES*16: packed int16 lanes; lane k = bits [16k+15:16k].
- `in_signed` in 1: lanes are two's complement when 1, unsigned when 0; applies to the whole vector.
- `in_mask` in LANES: lane enable; a 0 bit forces that output lane to 16'h0000.
- `out_valid` out 1: result vector valid.
- `out_ready` in 1: downstream accepts result.
- `out_data` out LANES*16: packed fp16 results, same lane order as `in_data`.
- `busy` out 1: high in CONV (and DRAIN when compiled).

## Operation
- FSM states: IDLE, CONV, DONE, plus DRAIN when `I2F_PIPE_EN` is compiled in.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `in_data`, `in_signed` and `in_mask`; clear the lane index to 0; go to CONV.
- **CONV**
  - Each cycle, lane[idx] goes to the converter and the result is written to `out_data` lane idx; a masked lane writes 0.
  - idx increments.
  - After writing lane LANES-1, go to DONE.
- **DONE**
  - `out_valid`=1; `out_data` stays stable until the handshake.
  - On `out_ready`: go to IDLE. If `in_valid` is also high in that cycle, accept the new vector and go straight to CONV (`in_ready` = IDLE | (DONE & `out_ready`)).
- **Conversion rules** (enforced by the converter; the bench checks them):
  - fp16 with bias 15, round-to-nearest-even.
  - 0 → 16'h0000.
  - Unsigned magnitudes ≥ 65520 round up to +Inf (16'h7C00).
  - Signed −32768 → 16'hF800.
  - No subnormals, no NaN.
- Lane index width: $clog2(LANES); it wraps only by the state transition and never by counter overflow.
- Latched inputs are not re-sampled during CONV; input changes during CONV/DONE are ignored.

## Timing
- Reset values:
  - state=IDLE, idx=0, `out_data`=0, `out_valid`=0, `busy`=0.
  - `in_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Latency: accept edge → `out_valid` high after LANES+1 edges (9 for LANES=8); LANES+2 with `I2F_PIPE_EN`.
- Throughput: one vector per LANES+1 cycles with `out_ready` tied high (back-to-back accept in DONE).
- `rst` asserted mid-CONV or mid-DONE: the vector is discarded, no partial `out_valid`, and all outputs return to reset values on the next edge.
- `out_valid` is never deasserted without `out_ready`, and `out_data` never changes while `out_valid` && !`out_ready`.

## Configuration
- `I2F_PIPE_EN`: when defined, a register stage is inserted after the converter.
  - Each lane's result is written one cycle after its lane is issued.
  - DRAIN is a single cycle between CONV and DONE that writes the last lane.
  - Latency becomes LANES+2.
- When undefined, the converter output is written in the same cycle as issue and there is no DRAIN state.

## Structure
- Shared package `smc_i2f_pkg`:
  - FSM state enum (`I2F_IDLE`, `I2F_CONV`, `I2F_DRAIN`, `I2F_DONE`).
  - Constants `FP16_POS_INF`=16'h7C00 and `FP16_ZERO`=16'h0000.
  - Lane-width constant 16.
- One sub-module: the existing combinational `int2fp16` scalar converter, instantiated once. No other hierarchy.

## Test plan
- Unsigned vector {1,2,1024,2049,2051,0,32768,65535} (lane0 first), mask FF → {3C00,4000,6400,6800,6802,0000,7800,7C00}; `out_valid` at cycle 9 after accept.
- Signed vector {1,−1,−32768,−2,100,0,7,−1024}, mask FF → {3C00,BC00,F800,C000,5640,0000,4700,E400}.
- Same unsigned vector as the first scenario with mask 8'b1010_0101 → lanes 1,3,4,6 = 0000; lanes 0,2,5,7 as in the first scenario.
- Hold `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 → `out_data` stable, `in_ready`=0; then `out_ready`=1 with `in_valid`=1 → same-edge accept, next `out_valid` LANES+1 cycles later.
- Assert `rst` at lane 4 of CONV → next edge `out_valid`=0, `out_data`=0, `busy`=0; a fresh vector converts correctly.
- With `I2F_PIPE_EN`: the first scenario's vector → identical values, `out_valid` at cycle 10.
